// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller that shares one 4511-style
// BCD-to-7-segment decoder across NUM_DIGITS common-cathode digits.
// Each digit gets a blanking gap followed by a lit dwell period. New digit
// values are double-buffered so that a frame in progress is never torn.
// Optional build macro: SEG_SCAN_LZB_EN enables leading-zero blanking.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    CP,
    input  logic                    MRN,
    input  logic                    ena,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [3:0]              bcd_out,
    output logic                    bi_n_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done,
    output logic                    busy
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int TMR_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t                  state, nxt_state;
    logic [IDX_W-1:0]        idx, nxt_idx;
    logic [TMR_W-1:0]        timer, nxt_timer;
    logic [4*NUM_DIGITS-1:0] active, nxt_active;
    logic [4*NUM_DIGITS-1:0] shadow, nxt_shadow;
    logic                    pending, nxt_pending;
    logic                    nxt_frame_done;

    // Select one BCD nibble out of the packed digit register.
    function automatic logic [3:0] digit_of(input logic [4*NUM_DIGITS-1:0] act,
                                            input logic [IDX_W-1:0]        k);
        return act[{k, 2'b00} +: 4];
    endfunction

`ifdef SEG_SCAN_LZB_EN
    // A digit is lit unless it and every more-significant digit are zero;
    // digit 0 always lights so a value of zero still shows "0".
    function automatic logic digit_lit(input logic [4*NUM_DIGITS-1:0] act,
                                       input logic [IDX_W-1:0]        k);
        logic nz;
        nz = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(k) && act[4*i +: 4] != 4'd0)
                nz = 1'b1;
        end
        return nz || (k == '0);
    endfunction
`endif

    // Next-state logic: scan sequencing plus shadow/active buffer handling.
    always_comb begin
        nxt_state      = state;
        nxt_idx        = idx;
        nxt_timer      = timer;
        nxt_active     = active;
        nxt_shadow     = shadow;
        nxt_pending    = pending;
        nxt_frame_done = 1'b0;

        if (load)
            nxt_shadow = digits_in;

        case (state)
            IDLE: begin
                // Nothing is being displayed, so new data goes straight live.
                if (load)
                    nxt_active = digits_in;
                if (ena) begin
                    nxt_state = BLANK;
                    nxt_idx   = '0;
                    nxt_timer = '0;
                end
            end
            BLANK: begin
                if (load)
                    nxt_pending = 1'b1;
                if (timer == TMR_W'(BLANK_CYCLES - 1)) begin
                    nxt_state = SHOW;
                    nxt_timer = '0;
                end else begin
                    nxt_timer = timer + TMR_W'(1);
                end
            end
            SHOW: begin
                if (timer == TMR_W'(DWELL_CYCLES - 1)) begin
                    nxt_timer = '0;
                    if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                        // Frame end: the only point where a running scan
                        // may take new data; a same-cycle load beats the shadow.
                        nxt_frame_done = 1'b1;
                        nxt_idx        = '0;
                        nxt_pending    = 1'b0;
                        if (load)
                            nxt_active = digits_in;
                        else if (pending)
                            nxt_active = shadow;
                        nxt_state = ena ? BLANK : IDLE;
                    end else begin
                        if (load)
                            nxt_pending = 1'b1;
                        nxt_idx   = idx + IDX_W'(1);
                        nxt_state = BLANK;
                    end
                end else begin
                    if (load)
                        nxt_pending = 1'b1;
                    nxt_timer = timer + TMR_W'(1);
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_idx   = '0;
                nxt_timer = '0;
            end
        endcase
    end

    // State, buffers and registered outputs; outputs follow the next state
    // so they line up cycle-for-cycle with the phase being entered.
    always_ff @(posedge CP or negedge MRN) begin
        if (!MRN) begin
            state      <= IDLE;
            idx        <= '0;
            timer      <= '0;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            bcd_out    <= 4'd0;
            bi_n_out   <= 1'b0;
            dig_sel    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= nxt_state;
            idx        <= nxt_idx;
            timer      <= nxt_timer;
            active     <= nxt_active;
            shadow     <= nxt_shadow;
            pending    <= nxt_pending;
            bcd_out    <= digit_of(nxt_active, nxt_idx);
`ifdef SEG_SCAN_LZB_EN
            bi_n_out   <= (nxt_state == SHOW) && digit_lit(nxt_active, nxt_idx);
`else
            bi_n_out   <= (nxt_state == SHOW);
`endif
            dig_sel    <= (nxt_state == SHOW) ? (NUM_DIGITS'(1) << nxt_idx) : '0;
            frame_done <= nxt_frame_done;
            busy       <= (nxt_state != IDLE);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: table-driven frames plus hand-written
// sequences, with a queue of expected lit digits checked by a monitor.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

    localparam int ND = 4;
    localparam int DW = 8;
    localparam int BC = 2;
    localparam int FRAME = ND * (BC + DW);
`ifdef SEG_SCAN_LZB_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        CP = 1'b0;
    logic        MRN = 1'b0;
    logic        ena = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = 16'h0;
    logic [3:0]  bcd_out;
    logic        bi_n_out;
    logic [3:0]  dig_sel;
    logic        frame_done;
    logic        busy;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BC)) dut (
        .CP(CP), .MRN(MRN), .ena(ena), .load(load), .digits_in(digits_in),
        .bcd_out(bcd_out), .bi_n_out(bi_n_out), .dig_sel(dig_sel),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 CP = ~CP;

    int cyc = 0;
    always @(posedge CP) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] bcd;
        logic       lit;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [15:0] d, input logic [3:0] lit, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.sel = 4'(1 << k);
            e.bcd = d[4*k +: 4];
            e.lit = lit[k];
            sb.push_back(e);
        end
    endtask

    // Monitor: at each SHOW start pop the expected digit; also track
    // dwell length, blank gap and frame_done width.
    logic [3:0] prev_sel = 4'h0;
    int         run = 0;
    int         gap = 0;
    logic       prev_fd = 1'b0;
    always @(negedge CP) begin
        exp_t e;
        if (!MRN) begin
            prev_sel = 4'h0;
            run = 0;
            gap = 0;
            prev_fd = 1'b0;
        end else begin
            if (dig_sel != 4'h0 && prev_sel == 4'h0) begin
                check("blank_gap", gap, BC);
                gap = 0;
                run = 1;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_show: dig_sel=%b bcd=%0h with empty queue", dig_sel, bcd_out);
                end else begin
                    e = sb.pop_front();
                    check("dig_sel", dig_sel, e.sel);
                    check("bcd_out", bcd_out, e.bcd);
                    check("bi_n_out", bi_n_out, e.lit);
                    check("onehot", $onehot(dig_sel), 1);
                end
            end else if (dig_sel != 4'h0) begin
                run++;
            end else if (prev_sel != 4'h0) begin
                check("dwell", run, DW);
                run = 0;
            end
            if (busy && dig_sel == 4'h0)
                gap++;
            if (frame_done)
                check("fd_width", {31'b0, prev_fd}, 0);
            prev_sel = dig_sel;
            prev_fd = frame_done;
        end
    end

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic load_idle(input logic [15:0] d);
        digits_in = d;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_fd(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge CP);
            if (frame_done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_frame_done: timeout after %0d cycles", budget);
        end
    endtask

    task automatic wait_sel(input logic [3:0] s, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CP);
            if (dig_sel == s) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_dig_sel: %b not seen within %0d cycles", s, budget);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_dig_sel"}, dig_sel, 0);
        check({tag, "_bi_n"}, bi_n_out, 0);
    endtask

    typedef struct {
        logic [15:0] d;
        logic [3:0]  lit;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int st;
        int fd;

        tbl[0] = '{16'h1234, 4'b1111};
        tbl[1] = '{16'h0070, LZ ? 4'b0011 : 4'b1111};
        tbl[2] = '{16'h0000, LZ ? 4'b0001 : 4'b1111};
        tbl[3] = '{16'h0A05, LZ ? 4'b0111 : 4'b1111};
        tbl[4] = '{16'hFFFF, 4'b1111};
        tbl[5] = '{16'h9000, 4'b1111};

        // Reset state
        MRN = 1'b0;
        #12;
        check("rst_bcd", bcd_out, 0);
        check("rst_bi_n", bi_n_out, 0);
        check("rst_dig_sel", dig_sel, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
        MRN = 1'b1;
        tick();

        // Table-driven single frames started from IDLE
        foreach (tbl[i]) begin
            load_idle(tbl[i].d);
            push_frame(tbl[i].d, tbl[i].lit, ND);
            ena = 1'b1;
            tick();
            st = cyc;
            ena = 1'b0;
            wait_fd(FRAME + 10, fd);
            check("frame_period", fd - st, FRAME);
            check_idle("post_frame");
        end

        // Mid-frame load is deferred to the next frame; ena drop mid-frame
        load_idle(16'h1234);
        push_frame(16'h1234, 4'b1111, ND);
        ena = 1'b1;
        tick();
        wait_sel(4'b0010, FRAME);
        digits_in = 16'h5678;
        load = 1'b1;
        tick();
        load = 1'b0;
        push_frame(16'h5678, 4'b1111, ND);
        wait_fd(FRAME + 10, fd);
        check("continue_busy", busy, 1);
        wait_sel(4'b0010, FRAME);
        ena = 1'b0;
        wait_fd(FRAME + 10, fd);
        check_idle("ena_drop");

        // Load on the frame-end cycle beats a pending shadow value
        load_idle(16'h2222);
        push_frame(16'h2222, 4'b1111, ND);
        ena = 1'b1;
        tick();
        wait_sel(4'b0010, FRAME);
        digits_in = 16'h1111;
        load = 1'b1;
        tick();
        load = 1'b0;
        wait_sel(4'b1000, FRAME);
        repeat (DW - 1) @(posedge CP);
        #1;
        digits_in = 16'h9999;
        load = 1'b1;
        push_frame(16'h9999, 4'b1111, ND);
        tick();
        load = 1'b0;
        check("fe_frame_done", frame_done, 1);
        wait_sel(4'b0010, FRAME);
        ena = 1'b0;
        wait_fd(FRAME + 10, fd);
        check_idle("fe_end");

        // Asynchronous reset mid-SHOW, then active digits must be zero
        load_idle(16'h1234);
        push_frame(16'h1234, 4'b1111, 2);
        ena = 1'b1;
        tick();
        ena = 1'b0;
        wait_sel(4'b0010, FRAME);
        #3;
        MRN = 1'b0;
        #1;
        check("arst_bi_n", bi_n_out, 0);
        check("arst_dig_sel", dig_sel, 0);
        check("arst_bcd", bcd_out, 0);
        check("arst_busy", busy, 0);
        @(negedge CP);
        #2;
        MRN = 1'b1;
        push_frame(16'h0000, LZ ? 4'b0001 : 4'b1111, ND);
        ena = 1'b1;
        tick();
        ena = 1'b0;
        wait_fd(FRAME + 10, fd);
        check_idle("arst_after");

        repeat (3) @(negedge CP);
        check("queue_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
